// File: rtl/gsensor_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : gsensor_spi_slave
// Description : Mode-3 SPI register slave with a 64-entry register map and a
//               sensor-sample capture port. GSENSOR_SPI_SLAVE_AUTOINC_EN
//               enables multi-byte address auto-increment.
// Revision    : 1.0 - initial release
// ============================================================================
module gsensor_spi_slave #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        spi_SCLK,
  input  logic        spi_MOSI,
  input  logic        spi_SS_n,
  output logic        spi_MISO,
  output logic        spi_MISO_oe,
  input  logic        smp_valid,
  output logic        smp_ready,
  input  logic [47:0] smp_data,
  output logic        wr_valid,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

`ifdef GSENSOR_SPI_SLAVE_AUTOINC_EN
  localparam logic c_AUTOINC = 1'b1;
`else
  localparam logic c_AUTOINC = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
  logic r_sclk_d, r_ss_d;
  logic w_sclk, w_mosi, w_ss;
  logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx;
  logic [7:0]  r_shift;
  logic        r_miso, r_oe;
  logic        r_rw, r_mb;
  logic [5:0]  r_addr;
  logic        r_wr_valid;
  logic [5:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic        r_alive;
  logic [47:0] r_smp;
  logic [7:0]  r_scratch [0:63];

  logic [7:0] w_byte;
  logic       w_byte_done;
  logic [5:0] w_next_addr;
  logic [5:0] w_rd_addr;
  logic [7:0] w_rd_data;
  logic       w_writable;
  logic       w_smp_hs;

  // Synchronizers preset high so a released reset never looks like an edge.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_sclk_sync <= '1;
      r_mosi_sync <= '1;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b1;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_MOSI};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_SS_n};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;

  assign w_byte      = {r_rx, w_mosi};
  assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7) && !w_ss_rise;
  assign w_next_addr = r_addr + {5'd0, r_mb & c_AUTOINC};
  assign w_writable  = (r_addr != 6'h00) && (r_addr <= 6'h31);
  // r_ss_d keeps ready high in the cycle an SS_n fall is detected.
  assign smp_ready   = r_alive && (r_state == ST_IDLE) && r_ss_d;
  assign w_smp_hs    = smp_valid & smp_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_ss_fall) w_state_nxt = ST_CMD;
      ST_CMD: begin
        if (w_ss_rise)        w_state_nxt = ST_IDLE;
        else if (w_byte_done) w_state_nxt = ST_DATA;
      end
      ST_DATA: if (w_ss_rise) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Command byte reads load from its own address; data bytes preload the next one.
  always_comb begin
    w_rd_addr = (r_state == ST_CMD) ? w_byte[5:0] : w_next_addr;
    w_rd_data = 8'h00;
    if (w_rd_addr == 6'h00) begin
      w_rd_data = DEVID;
    end else if (w_rd_addr <= 6'h31) begin
      w_rd_data = r_scratch[w_rd_addr];
    end else begin
      case (w_rd_addr)
        6'h32:   w_rd_data = r_smp[7:0];
        6'h33:   w_rd_data = r_smp[15:8];
        6'h34:   w_rd_data = r_smp[23:16];
        6'h35:   w_rd_data = r_smp[31:24];
        6'h36:   w_rd_data = r_smp[39:32];
        6'h37:   w_rd_data = r_smp[47:40];
        default: w_rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_bit_cnt  <= 3'd0;
      r_rx       <= 7'd0;
      r_shift    <= 8'h00;
      r_miso     <= 1'b0;
      r_oe       <= 1'b0;
      r_rw       <= 1'b0;
      r_mb       <= 1'b0;
      r_addr     <= 6'd0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 6'd0;
      r_wr_data  <= 8'h00;
      r_alive    <= 1'b0;
      r_smp      <= 48'd0;
      for (int i = 0; i < 64; i++) r_scratch[i] <= 8'h00;
    end else begin
      r_alive    <= 1'b1;
      r_wr_valid <= 1'b0;
      if (w_smp_hs) r_smp <= smp_data;

      if (w_ss_rise || (r_state == ST_IDLE)) begin
        r_bit_cnt <= 3'd0;
        r_oe      <= 1'b0;
        r_miso    <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          r_rx      <= w_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_byte_done) begin
          if (r_state == ST_CMD) begin
            r_rw   <= w_byte[7];
            r_mb   <= w_byte[6];
            r_addr <= w_byte[5:0];
            if (w_byte[7]) begin
              r_shift <= w_rd_data;
              r_oe    <= 1'b1;
            end
          end else begin
            r_addr <= w_next_addr;
            if (r_rw) begin
              r_shift <= w_rd_data;
            end else if (w_writable) begin
              r_scratch[r_addr] <= w_byte;
              r_wr_valid        <= 1'b1;
              r_wr_addr         <= r_addr;
              r_wr_data         <= w_byte;
            end
          end
        end
        if (w_sclk_fall && r_oe) begin
          r_miso  <= r_shift[7];
          r_shift <= {r_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi_MISO    = r_miso & r_oe;
  assign spi_MISO_oe = r_oe;
  assign wr_valid    = r_wr_valid;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_gsensor_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_gsensor_spi_slave
// Description : Randomized scoreboard bench for gsensor_spi_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gsensor_spi_slave;

`ifdef GSENSOR_SPI_SLAVE_AUTOINC_EN
  localparam bit c_AUTOINC = 1'b1;
`else
  localparam bit c_AUTOINC = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        spi_SCLK = 1'b1, spi_MOSI = 1'b1, spi_SS_n = 1'b1;
  logic        spi_MISO, spi_MISO_oe;
  logic        smp_valid = 1'b0, smp_ready;
  logic [47:0] smp_data = 48'd0;
  logic        wr_valid;
  logic [5:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  gsensor_spi_slave dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .spi_SCLK(spi_SCLK), .spi_MOSI(spi_MOSI), .spi_SS_n(spi_SS_n),
    .spi_MISO(spi_MISO), .spi_MISO_oe(spi_MISO_oe),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference register map
  logic [7:0]  m_scr [0:63];
  logic [47:0] m_smp;
  logic [7:0]  txd [0:5];

  logic [13:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  got_rd [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  function automatic logic [7:0] m_read(input logic [5:0] a);
    logic [47:0] v;
    if (a == 6'h00) return 8'hE5;
    if (a <= 6'h31) return m_scr[a];
    if (a <= 6'h37) begin
      v = m_smp >> (8 * (int'(a) - 50));
      return v[7:0];
    end
    return 8'h00;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 64; i++) m_scr[i] = 8'h00;
    m_smp = 48'd0;
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a read byte
  always @(negedge clk_clk) begin
    logic [13:0] e;
    if (wr_valid) begin
      if (exp_wr.size() == 0) begin
        n_total++; n_bad++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected none", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", {58'd0, wr_addr}, {58'd0, e[13:8]});
        chk("wr_data", {56'd0, wr_data}, {56'd0, e[7:0]});
      end
    end
    while (got_rd.size() > 0) begin
      if (exp_rd.size() == 0) begin
        n_total++; n_bad++;
        $display("FAIL rd_unexpected: got %0h expected none", got_rd.pop_front());
      end else begin
        chk("rd_byte", {56'd0, got_rd.pop_front()}, {56'd0, exp_rd.pop_front()});
      end
    end
    if (!spi_MISO_oe) chk("miso_when_off", {63'd0, spi_MISO}, 64'd0);
  end

  task automatic xfer_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_SCLK = 1'b0;
      spi_MOSI = tx[7-i];
      tick(5);
      rx = {rx[6:0], spi_MISO};
      spi_SCLK = 1'b1;
      tick(5);
    end
  endtask

  task automatic put_sample(input logic [47:0] v);
    int k;
    smp_data  = v;
    smp_valid = 1'b1;
    k = 0;
    while (!smp_ready && k < 50) begin tick(1); k++; end
    chk("smp_handshake", {63'd0, smp_ready}, 64'd1);
    tick(1);
    smp_valid = 1'b0;
    m_smp = v;
  endtask

  // One SPI transaction; cut>0 truncates the last data byte to cut bits,
  // stash holds a new sample valid throughout the transfer.
  task automatic do_xfer(input bit rw, input bit mb, input logic [5:0] addr, input int n,
                         input int cut, input bit stash, input logic [47:0] sval);
    logic [5:0] a;
    logic [7:0] rx;
    int nb, k;
    a = addr;
    for (int j = 0; j < n; j++) begin
      if (cut > 0 && j == n - 1) break;
      if (rw) exp_rd.push_back(m_read(a));
      else if (a != 6'h00 && a <= 6'h31) begin
        m_scr[a] = txd[j];
        exp_wr.push_back({a, txd[j]});
      end
      if (mb && c_AUTOINC) a = a + 6'd1;
    end
    spi_SS_n = 1'b0;
    tick(6);
    chk("busy_in_xfer", {63'd0, busy}, 64'd1);
    if (stash) begin smp_data = sval; smp_valid = 1'b1; end
    xfer_byte({rw, mb, addr}, 8, rx);
    chk("oe_after_cmd", {63'd0, spi_MISO_oe}, {63'd0, rw});
    for (int j = 0; j < n; j++) begin
      nb = (cut > 0 && j == n - 1) ? cut : 8;
      xfer_byte(txd[j], nb, rx);
      if (rw && nb == 8) got_rd.push_back(rx);
      if (stash) chk("ready_low_in_xfer", {63'd0, smp_ready}, 64'd0);
    end
    tick(3);
    spi_SS_n = 1'b1;
    if (stash) begin
      k = 0;
      while (!smp_ready && k < 20) begin tick(1); k++; end
      chk("stash_capture_latency", {63'd0, (k <= 6)}, 64'd1);
      chk("stash_idle", {63'd0, busy}, 64'd0);
      tick(1);
      smp_valid = 1'b0;
      m_smp = sval;
    end
    tick(8);
    chk("oe_after_ss", {63'd0, spi_MISO_oe}, 64'd0);
    chk("busy_after_ss", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [7:0] rx;
    m_clear();
    tick(3);
    chk("rst_miso", {63'd0, spi_MISO}, 64'd0);
    chk("rst_oe", {63'd0, spi_MISO_oe}, 64'd0);
    chk("rst_wr_valid", {63'd0, wr_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, smp_ready}, 64'd0);
    reset_reset = 1'b0;
    tick(1);
    chk("ready_after_rst", {63'd0, smp_ready}, 64'd1);

    // Device ID read, then write/readback of a scratch register
    do_xfer(1'b1, 1'b0, 6'h00, 1, 0, 1'b0, 48'd0);
    txd[0] = 8'h3C;
    do_xfer(1'b0, 1'b0, 6'h05, 1, 0, 1'b0, 48'd0);
    do_xfer(1'b1, 1'b0, 6'h05, 1, 0, 1'b0, 48'd0);

    // Sample capture and multi-byte read of the sample bytes
    put_sample(48'h0003_0002_0001);
    do_xfer(1'b1, 1'b1, 6'h32, 6, 0, 1'b0, 48'd0);
    do_xfer(1'b1, 1'b1, 6'h32, 6, 0, 1'b1, 48'h0006_0005_0004);
    do_xfer(1'b1, 1'b1, 6'h32, 6, 0, 1'b0, 48'd0);

    // Aborted partial write must not commit
    txd[0] = 8'h11;
    do_xfer(1'b0, 1'b0, 6'h07, 1, 0, 1'b0, 48'd0);
    txd[0] = 8'h99;
    do_xfer(1'b0, 1'b0, 6'h07, 1, 4, 1'b0, 48'd0);
    do_xfer(1'b1, 1'b0, 6'h07, 1, 0, 1'b0, 48'd0);

    // Multi-byte write across read-only top and wrap to DEVID
    txd[0] = 8'hAA; txd[1] = 8'hBB; txd[2] = 8'hCC;
    do_xfer(1'b0, 1'b1, 6'h3E, 3, 0, 1'b0, 48'd0);
    do_xfer(1'b1, 1'b0, 6'h00, 1, 0, 1'b0, 48'd0);
    do_xfer(1'b1, 1'b1, 6'h3E, 3, 0, 1'b0, 48'd0);

    // Reset in the middle of a write transfer clears everything
    spi_SS_n = 1'b0;
    tick(6);
    xfer_byte(8'h05, 8, rx);
    xfer_byte(8'h5A, 3, rx);
    reset_reset = 1'b1;
    spi_SS_n = 1'b1;
    spi_SCLK = 1'b1;
    tick(1);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_oe", {63'd0, spi_MISO_oe}, 64'd0);
    tick(2);
    reset_reset = 1'b0;
    m_clear();
    tick(3);
    do_xfer(1'b1, 1'b1, 6'h05, 2, 0, 1'b0, 48'd0);
    do_xfer(1'b1, 1'b1, 6'h32, 2, 0, 1'b0, 48'd0);

    // Randomized traffic against the reference map
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0)
        put_sample({$urandom(), $urandom()} & 48'hFFFF_FFFF_FFFF);
      for (int j = 0; j < 6; j++) txd[j] = 8'($urandom());
      do_xfer(1'($urandom()), 1'($urandom()), 6'($urandom()),
              int'($urandom_range(1, 4)), 0, 1'b0, 48'd0);
    end

    tick(4);
    chk("exp_wr_drained", exp_wr.size(), 64'd0);
    chk("exp_rd_drained", exp_rd.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
